// File: rtl/regfile_wr_ctrl.sv
// rtl/regfile_wr_ctrl.sv - round-robin write-port controller with register-0 drop and zeroing sweep
// Arbitrates ALU/load writeback onto the single register-file write port.
module regfile_wr_ctrl #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic          Clk,
  input  logic          Clr,
  input  logic          Init,
  output logic          Busy,
  input  logic          Req0,
  input  logic          Req1,
  input  logic [AW-1:0] A0,
  input  logic [AW-1:0] A1,
  input  logic [DW-1:0] D0,
  input  logic [DW-1:0] D1,
  output logic          Gnt0,
  output logic          Gnt1,
  output logic          We,
  output logic [AW-1:0] Wa,
  output logic [DW-1:0] Wd
);

  typedef enum logic {IDLE, SWEEP} state_t;

  localparam logic [AW-1:0] LAST_REG = AW'(NREG - 1);

  state_t        state_q, state_d;
  logic          prio_q, prio_d;
  logic          we_q, we_d;
  logic [AW-1:0] wa_q, wa_d;
  logic [DW-1:0] wd_q, wd_d;

  // Grant decode sees only Req/Init/Clr/state/prio so A/D never reach Gnt.
  always_comb begin
    Gnt0 = 1'b0;
    Gnt1 = 1'b0;
    if (!Clr && state_q == IDLE && !Init) begin
      if (Req0 && (!Req1 || !prio_q)) begin
        Gnt0 = 1'b1;
      end else if (Req1) begin
        Gnt1 = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    we_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    if (Clr) begin
      state_d = IDLE;
      prio_d  = 1'b0;
      wa_d    = '0;
      wd_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Init) begin
            state_d = SWEEP;
            we_d    = 1'b1;
            wa_d    = AW'(1);
            wd_d    = '0;
          end else if (Gnt0) begin
            prio_d = 1'b1;
            we_d   = (A0 != '0);
            wa_d   = A0;
            wd_d   = D0;
          end else if (Gnt1) begin
            prio_d = 1'b0;
            we_d   = (A1 != '0);
            wa_d   = A1;
            wd_d   = D1;
          end
        end
        SWEEP: begin
          // Last swept register stays on Wa; We drops as we return to IDLE.
          if (wa_q == LAST_REG) begin
            state_d = IDLE;
          end else begin
            we_d = 1'b1;
            wa_d = wa_q + AW'(1);
            wd_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
    end
  end

  assign We   = we_q;
  assign Wa   = wa_q;
  assign Wd   = wd_q;
  assign Busy = (state_q == SWEEP);

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// tb/tb_regfile_wr_ctrl.sv - scoreboard bench for regfile_wr_ctrl
// Stimulus pushes time-stamped grant/write expectations; a negedge monitor pops and compares.
module tb_regfile_wr_ctrl;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic          Clk = 1'b0;
  logic          Clr = 1'b1;
  logic          Init = 1'b0;
  logic          Busy;
  logic          Req0 = 1'b0, Req1 = 1'b0;
  logic [AW-1:0] A0 = '0, A1 = '0;
  logic [DW-1:0] D0 = '0, D1 = '0;
  logic          Gnt0, Gnt1;
  logic          We;
  logic [AW-1:0] Wa;
  logic [DW-1:0] Wd;

  regfile_wr_ctrl #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
    .Clk(Clk), .Clr(Clr), .Init(Init), .Busy(Busy),
    .Req0(Req0), .Req1(Req1), .A0(A0), .A1(A1), .D0(D0), .D1(D1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .We(We), .Wa(Wa), .Wd(Wd)
  );

  always #5 Clk = ~Clk;

  typedef struct { int stamp; int port; } g_t;
  typedef struct { int stamp; logic [AW-1:0] wa; logic [DW-1:0] wd; } w_t;

  g_t gq[$];
  w_t wq[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_g(input int stamp, input int port);
    g_t e;
    e.stamp = stamp; e.port = port;
    gq.push_back(e);
  endtask

  task automatic exp_w(input int stamp, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    w_t e;
    e.stamp = stamp; e.wa = wa; e.wd = wd;
    wq.push_back(e);
  endtask

  task automatic set_in(input logic r0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic r1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input logic init, input logic clr);
    Req0 = r0; A0 = a0; D0 = d0;
    Req1 = r1; A1 = a1; D1 = d1;
    Init = init; Clr = clr;
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Monitor: every grant and every We pulse must match the head of its queue at the right cycle.
  always @(negedge Clk) begin
    while (gq.size() > 0 && gq[0].stamp < cyc) begin
      checks++; errors++;
      $display("FAIL grant_missing: got none expected port %0d at cycle %0d", gq[0].port, gq[0].stamp);
      void'(gq.pop_front());
    end
    while (wq.size() > 0 && wq[0].stamp < cyc) begin
      checks++; errors++;
      $display("FAIL write_missing: got none expected wa=%0d wd=0x%0h at cycle %0d", wq[0].wa, wq[0].wd, wq[0].stamp);
      void'(wq.pop_front());
    end
    if (Gnt0 === 1'b1 || Gnt1 === 1'b1) begin
      checks++;
      if (Gnt0 === 1'b1 && Gnt1 === 1'b1) begin
        errors++;
        $display("FAIL grant_onehot: got both grants expected at most one (cycle %0d)", cyc);
      end else if (gq.size() == 0 || gq[0].stamp != cyc) begin
        errors++;
        $display("FAIL grant_unexpected: got port %0d expected none (cycle %0d)", Gnt0 ? 0 : 1, cyc);
      end else begin
        if (gq[0].port != (Gnt0 ? 0 : 1)) begin
          errors++;
          $display("FAIL grant_port: got %0d expected %0d (cycle %0d)", Gnt0 ? 0 : 1, gq[0].port, cyc);
        end
        void'(gq.pop_front());
      end
    end
    if (We === 1'b1) begin
      checks++;
      if (wq.size() == 0 || wq[0].stamp != cyc) begin
        errors++;
        $display("FAIL write_unexpected: got wa=%0d wd=0x%0h expected no write (cycle %0d)", Wa, Wd, cyc);
      end else begin
        if (Wa !== wq[0].wa || Wd !== wq[0].wd) begin
          errors++;
          $display("FAIL write_data: got wa=%0d wd=0x%0h expected wa=%0d wd=0x%0h (cycle %0d)",
                   Wa, Wd, wq[0].wa, wq[0].wd, cyc);
        end
        void'(wq.pop_front());
      end
    end
  end

  initial begin
    int nb;
    // Reset with both requests high: no grants allowed.
    set_in(1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 0, 1);
    tick;
    @(negedge Clk);
    chk("reset_we", We, 0);
    chk("reset_wa", Wa, 0);
    chk("reset_wd", Wd, 0);
    chk("reset_busy", Busy, 0);
    chk("reset_gnt", {Gnt0, Gnt1}, 0);
    tick;

    // Single port write.
    set_in(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 0, 0);
    exp_g(cyc, 0); exp_w(cyc + 1, 5'd5, 32'hDEADBEEF);
    tick;
    set_in(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
    tick;
    @(negedge Clk);
    chk("single_we_drop", We, 0);
    tick;

    // Round-robin from reset priority.
    set_in(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 1);
    tick;
    set_in(1, 5'd3, 32'h30, 1, 5'd7, 32'h70, 0, 0);
    for (int i = 0; i < 4; i++) begin
      exp_g(cyc, i % 2);
      exp_w(cyc + 1, (i % 2) ? 5'd7 : 5'd3, (i % 2) ? 32'h70 : 32'h30);
      tick;
    end
    set_in(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
    tick;

    // Register 0 drop, then the conflict goes to port 0.
    set_in(1, 5'd9, 32'h99, 0, 5'd0, 32'h0, 0, 0);
    exp_g(cyc, 0); exp_w(cyc + 1, 5'd9, 32'h99);
    tick;
    set_in(0, 5'd0, 32'h0, 1, 5'd0, 32'h1234, 0, 0);
    exp_g(cyc, 1);
    tick;
    set_in(1, 5'd2, 32'h22, 1, 5'd4, 32'h44, 0, 0);
    @(negedge Clk);
    chk("reg0_we", We, 0);
    exp_g(cyc, 0); exp_w(cyc + 1, 5'd2, 32'h22);
    tick;

    // Back-to-back to port 0, then a conflict with prio on port 1.
    set_in(1, 5'd6, 32'h66, 0, 5'd0, 32'h0, 0, 0);
    exp_g(cyc, 0); exp_w(cyc + 1, 5'd6, 32'h66);
    tick;
    set_in(1, 5'd8, 32'h88, 0, 5'd0, 32'h0, 0, 0);
    exp_g(cyc, 0); exp_w(cyc + 1, 5'd8, 32'h88);
    tick;
    set_in(1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0, 0, 0);
    exp_g(cyc, 1); exp_w(cyc + 1, 5'd11, 32'hB0);
    tick;

    // Full sweep with Req0 held; prio is 0 so port 0 wins afterwards.
    set_in(1, 5'd12, 32'hC0, 0, 5'd0, 32'h0, 1, 0);
    for (int i = 1; i < NREG; i++) exp_w(cyc + i, AW'(i), 32'h0);
    tick;
    Init = 1'b0;
    nb = 0;
    for (int i = 1; i < NREG; i++) begin
      @(negedge Clk);
      if (Busy === 1'b1) nb++;
      tick;
    end
    chk("sweep_busy_cycles", nb, NREG - 1);
    exp_g(cyc, 0); exp_w(cyc + 1, 5'd12, 32'hC0);
    @(negedge Clk);
    chk("sweep_busy_end", Busy, 0);
    tick;
    set_in(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
    tick;

    // Sweep aborted by Clr at Wa=10, pending Req1 granted right after.
    set_in(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 0);
    for (int i = 1; i <= 10; i++) exp_w(cyc + i, AW'(i), 32'h0);
    tick;
    Init = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i == 5) begin Req1 = 1'b1; A1 = 5'd15; D1 = 32'hF0; end
      tick;
    end
    Clr = 1'b1;
    @(negedge Clk);
    chk("abort_wa_before", Wa, 10);
    chk("abort_busy_before", Busy, 1);
    tick;
    Clr = 1'b0;
    exp_g(cyc, 1); exp_w(cyc + 1, 5'd15, 32'hF0);
    @(negedge Clk);
    chk("abort_we", We, 0);
    chk("abort_wa", Wa, 0);
    chk("abort_busy", Busy, 0);
    tick;
    set_in(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 0);
    repeat (3) tick;

    @(negedge Clk);
    #1;
    chk("grant_queue_empty", gq.size(), 0);
    chk("write_queue_empty", wq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
